// File: rtl/pulse_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_multiplier_pkg
// Description : Shared state encoding and word constants for pulse_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_multiplier_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_BURST = 1'b1;

    // Width-agnostic constants; users cast them to their own word width.
    localparam int WORD_ZERO = 0;
    localparam int WORD_ONE  = 1;

endpackage
`default_nettype wire

// File: rtl/binary_counter.sv
`default_nettype none
// ============================================================================
// Module      : binary_counter
// Description : Loadable binary down-counter; decrements while running and
//               holds at zero. Load has priority over counting.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_counter
    import pulse_multiplier_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_run,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(WORD_ONE);
    localparam logic [WIDTH-1:0] c_zero = WIDTH'(WORD_ZERO);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_zero;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_run && (r_count != c_zero)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pending_counter.sv
`default_nettype none
// ============================================================================
// Module      : pending_counter
// Description : Saturating up/down counter. An increment at full scale without
//               a matching decrement is dropped and sets a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pending_counter
    import pulse_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(WORD_ONE);
    localparam logic [WIDTH-1:0] c_zero = WIDTH'(WORD_ZERO);
    localparam logic [WIDTH-1:0] c_max  = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= c_zero;
            r_overflow <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (r_count == c_max) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_one;
                end
            end else if (dec && !inc && (r_count != c_zero)) begin
                r_count <= r_count - c_one;
            end
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pulse_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : pulse_multiplier
// Description : Expands each input pulse into `multiplier` output pulses;
//               pulses arriving mid-burst are queued in a saturating counter.
//               Define PULSE_MULTIPLIER_GAP_EN for one low cycle after each
//               output pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_multiplier
    import pulse_multiplier_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int PENDING_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] multiplier,
    input  logic                  pulses_in,
    output logic                  pulse_out,
    output logic                  busy,
    output logic                  pending_overflow
);

`ifdef PULSE_MULTIPLIER_GAP_EN
    // Each output pulse occupies a high and a low phase, so count phases.
    localparam int c_cnt_width = WORD_WIDTH + 1;
`else
    localparam int c_cnt_width = WORD_WIDTH;
`endif

    localparam logic [c_cnt_width-1:0] c_cnt_one   = c_cnt_width'(WORD_ONE);
    localparam logic [WORD_WIDTH-1:0]  c_word_zero = WORD_WIDTH'(WORD_ZERO);

    state_t                   r_state;
    logic                     r_pulse_out;
    logic [c_cnt_width-1:0]   w_remaining;
    logic [c_cnt_width-1:0]   w_load_value;
    logic [PENDING_WIDTH-1:0] w_pending;
    logic                     w_overflow;
    logic                     w_mult_nonzero;
    logic                     w_last_cycle;
    logic                     w_burst_start;
    logic                     w_pulse_next;

    assign w_mult_nonzero = (multiplier != c_word_zero);
    assign w_last_cycle   = (r_state == ST_BURST) && (w_remaining == c_cnt_one);
    assign w_burst_start  = ((r_state == ST_IDLE) || w_last_cycle)
                            && (pulses_in || (w_pending != '0));

`ifdef PULSE_MULTIPLIER_GAP_EN
    assign w_load_value = {multiplier, 1'b0};
    // Even phase counts are the high halves of each pulse.
    assign w_pulse_next = w_burst_start ? w_mult_nonzero
                        : (w_remaining[0] && (w_remaining > c_cnt_one));
`else
    assign w_load_value = multiplier;
    assign w_pulse_next = w_burst_start ? w_mult_nonzero
                        : (w_remaining > c_cnt_one);
`endif

    binary_counter #(
        .WIDTH        (c_cnt_width)
    ) u_burst_counter (
        .clk          (clock),
        .rst          (clear),
        .i_load       (w_burst_start),
        .i_load_value (w_load_value),
        .i_run        (1'b1),
        .o_count      (w_remaining)
    );

    pending_counter #(
        .WIDTH    (PENDING_WIDTH)
    ) u_pending (
        .clk      (clock),
        .rst      (clear),
        .inc      (pulses_in),
        .dec      (w_burst_start),
        .count    (w_pending),
        .overflow (w_overflow)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= ST_IDLE;
            r_pulse_out <= 1'b0;
        end else begin
            r_pulse_out <= w_pulse_next;
            case (r_state)
                ST_IDLE: begin
                    // A zero multiplier consumes its pulse without leaving IDLE.
                    if (w_burst_start && w_mult_nonzero) begin
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_last_cycle) begin
                        r_state <= (w_burst_start && w_mult_nonzero) ? ST_BURST : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pulse_out        = r_pulse_out;
    assign busy             = (r_state == ST_BURST) || (w_pending != '0);
    assign pending_overflow = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pulse_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_multiplier
// Description : Self-checking bench for pulse_multiplier: directed table,
//               corner-case sequences and random traffic against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_multiplier;

    localparam int WW   = 16;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;
`ifdef PULSE_MULTIPLIER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          pulses_in = 1'b0;
    logic [WW-1:0] multiplier = '0;
    logic          pulse_out;
    logic          busy;
    logic          pending_overflow;

    always #5 clock = ~clock;

    pulse_multiplier #(
        .WORD_WIDTH       (WW),
        .PENDING_WIDTH    (PW)
    ) dut (
        .clock            (clock),
        .clear            (clear),
        .multiplier       (multiplier),
        .pulses_in        (pulses_in),
        .pulse_out        (pulse_out),
        .busy             (busy),
        .pending_overflow (pending_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Model: future output timeline plus the cycle at which the current burst ends.
    longint cyc      = 0;
    longint end_time = 0;
    int     pend     = 0;
    bit     ovf      = 0;
    bit     sched [256];
    bit     exp_pulse, exp_busy, exp_ovf;

    int high_count = 0;
    int cur_run    = 0;
    int max_run    = 0;
    int hist       = 0;
    int step_idx   = 0;

    typedef struct {
        bit p;
        int m;
        bit e_pulse;
        bit e_busy;
        bit e_ovf;
    } vec_t;
    vec_t tbl [$];

    function automatic void model_step(bit c, bit p, int m);
        bit start;
        if (c) begin
            pend     = 0;
            ovf      = 0;
            end_time = cyc;
            foreach (sched[i]) sched[i] = 0;
        end else begin
            start = (cyc >= end_time) && (p || pend != 0);
            if (start) begin
                for (int k = 1; k <= m; k++)
                    sched[int'((cyc + longint'(GAP ? 2*k-1 : k)) % 256)] = 1;
                end_time = cyc + longint'(GAP ? 2*m : m);
            end
            if (p && !start) begin
                if (pend == PMAX) ovf = 1;
                else pend++;
            end else if (!p && start) begin
                pend--;
            end
        end
        cyc++;
        exp_pulse = sched[int'(cyc % 256)];
        sched[int'(cyc % 256)] = 0;
        exp_busy  = (cyc <= end_time) || (pend != 0);
        exp_ovf   = ovf;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_stats();
        high_count = 0;
        cur_run    = 0;
        max_run    = 0;
        hist       = 0;
        step_idx   = 0;
    endtask

    task automatic step(input bit c, input bit p, input int m);
        clear      = c;
        pulses_in  = p;
        multiplier = WW'(m);
        model_step(c, p, m);
        @(posedge clock);
        #1;
        check("pulse_out", pulse_out, exp_pulse);
        check("busy", busy, exp_busy);
        check("overflow", pending_overflow, exp_ovf);
        if (pulse_out === 1'b1) begin
            high_count++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (step_idx < 31) hist = hist | (1 << step_idx);
        end else begin
            cur_run = 0;
        end
        step_idx++;
    endtask

    initial begin
        int m_rand;

        // Reset state
        step(1, 0, 0);
        step(1, 1, 3);
        check("reset_pulse", pulse_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ovf", pending_overflow, 1'b0);
        step(0, 0, 3);

        // Directed table: single bursts, back-to-back M=1, M=0
`ifdef PULSE_MULTIPLIER_GAP_EN
        tbl.push_back('{1, 3, 1, 1, 0});
        tbl.push_back('{0, 3, 0, 1, 0});
        tbl.push_back('{0, 3, 1, 1, 0});
        tbl.push_back('{0, 3, 0, 1, 0});
        tbl.push_back('{0, 3, 1, 1, 0});
        tbl.push_back('{0, 3, 0, 1, 0});
        tbl.push_back('{0, 3, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 0});
`else
        tbl.push_back('{1, 3, 1, 1, 0});
        tbl.push_back('{0, 3, 1, 1, 0});
        tbl.push_back('{0, 3, 1, 1, 0});
        tbl.push_back('{0, 3, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 0});
`endif
        tbl.push_back('{1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            step(0, tbl[i].p, tbl[i].m);
            check("tbl_pulse", pulse_out, tbl[i].e_pulse);
            check("tbl_busy", busy, tbl[i].e_busy);
            check("tbl_ovf", pending_overflow, tbl[i].e_ovf);
        end

        // Queued pulses, M=4
        step(1, 0, 4);
        reset_stats();
        step(0, 1, 4);
        step(0, 1, 4);
        for (int i = 0; i < 20; i++) step(0, 0, 4);
        check_int("queued_highs", high_count, 8);
        check_int("queued_run", max_run, GAP ? 1 : 8);

        // Two pulses, M=2: exact output positions
        step(1, 0, 2);
        reset_stats();
        step(0, 1, 2);
        step(0, 1, 2);
        for (int i = 0; i < 10; i++) step(0, 0, 2);
        check_int("m2_pattern", hist, GAP ? 32'h55 : 32'h0F);

        // M=0, three input pulses
        step(1, 0, 0);
        reset_stats();
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check_int("m0_highs", high_count, 0);
        check("m0_idle", busy, 1'b0);

        // M=1, pulses_in held for 10 cycles
        step(1, 0, 1);
        reset_stats();
        for (int i = 0; i < 10; i++) step(0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        check_int("m1_highs", high_count, GAP ? 8 : 10);

        // Overflow: M=8 held 6 cycles with a 2-bit pending counter
        step(1, 0, 8);
        reset_stats();
        for (int i = 0; i < 6; i++) step(0, 1, 8);
        for (int i = 0; i < 70; i++) step(0, 0, 8);
        check_int("ovf_highs", high_count, 32);
        check("ovf_sticky", pending_overflow, 1'b1);
        step(1, 0, 8);
        check("ovf_cleared", pending_overflow, 1'b0);

        // Multiplier changes 3 -> 5 while the first burst runs
        reset_stats();
        step(0, 1, 3);
        step(0, 1, 3);
        for (int i = 0; i < 14; i++) step(0, 0, 5);
        check_int("mchange_highs", high_count, 8);

        // Clear at the second output cycle drops the burst and the queue
        step(1, 0, 4);
        step(0, 1, 4);
        step(0, 1, 4);
        reset_stats();
        step(1, 1, 4);
        check("clr_pulse", pulse_out, 1'b0);
        check("clr_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 0, 4);
        check_int("clr_highs", high_count, 0);

        // Random traffic against the model
        m_rand = 3;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) m_rand = int'($urandom_range(0, 5));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 45, m_rand);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
